// File: rtl/spi_select_sequencer_pkg.sv
// Shared definitions for the SPI select sequencer.
// Holds the flash select bus addresses, the sequencer state encoding,
// the pending-command encoding and a small state-decode helper.
package spi_select_sequencer_pkg;

  // Bus addresses (ab_buf[18:8]) of the two flash select registers.
  localparam logic [10:0] TBIOM_SPI_SEL_FLASH_1 = 11'h7A0;
  localparam logic [10:0] TBIOM_SPI_SEL_FLASH_2 = 11'h7A1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_MISO_OFF = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_GUARD    = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_REQ1 = 2'd1,
    PEND_REQ2 = 2'd2,
    PEND_REL  = 2'd3
  } pend_cmd_e;

  // True in every state where the selected flash has its chip-select low.
  function automatic logic cs_driven(input seq_state_e st);
    logic res;
    case (st)
      ST_CS_SETUP, ST_ACTIVE, ST_MISO_OFF, ST_CS_HOLD: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_select_sequencer_bus_event_detect.sv
// Bus command decoder for the SPI select sequencer.
// Detects falling edges of the debounced write/read strobes and compares the
// address on that cycle only, producing single-cycle command pulses.
//   clk_i, rst_ni   : clock, async active-low reset
//   we_n_i, re_n_i  : debounced write/read strobes, active low
//   addr_i          : registered address bus [18:8]
//   rel_mask_i      : [0]/[1] flash 1/2 is selected or pending (read releases it)
//   req1_o, req2_o  : write to flash 1/2 select address
//   rel_o           : release read of the selected/pending flash
module spi_select_sequencer_bus_event_detect
  import spi_select_sequencer_pkg::*;
#(
  parameter logic [10:0] ADDR_SEL_1 = TBIOM_SPI_SEL_FLASH_1,
  parameter logic [10:0] ADDR_SEL_2 = TBIOM_SPI_SEL_FLASH_2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_n_i,
  input  logic        re_n_i,
  input  logic [10:0] addr_i,
  input  logic [1:0]  rel_mask_i,
  output logic        req1_o,
  output logic        req2_o,
  output logic        rel_o
);

  logic we_n_q;
  logic re_n_q;
  logic we_ev;
  logic re_ev;
  logic hit1;
  logic hit2;

  // Previous-cycle strobe levels; idle level of both strobes is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_n_q <= 1'b1;
      re_n_q <= 1'b1;
    end else begin
      we_n_q <= we_n_i;
      re_n_q <= re_n_i;
    end
  end

  assign we_ev = we_n_q & ~we_n_i;
  assign re_ev = re_n_q & ~re_n_i;
  assign hit1  = (addr_i == ADDR_SEL_1);
  assign hit2  = (addr_i == ADDR_SEL_2);

  assign req1_o = we_ev & hit1;
  assign req2_o = we_ev & hit2;
  // A simultaneous write event wins; the read is discarded.
  assign rel_o  = re_ev & ~we_ev & ((hit1 & rel_mask_i[0]) | (hit2 & rel_mask_i[1]));

endmodule

// File: rtl/spi_select_sequencer.sv
// SPI chip-select / MISO buffer sequencer for the two serial flash devices.
// Enforces break-before-make, CS-to-MISO setup, hold and a guard interval so
// both selects are never low together and MISO is never driven during a change.
//   clkDspIn, dsp_reset     : DSP clock, async active-low reset
//   we_deb, re_deb, ab_buf  : debounced bus strobes (active low) and address [18:8]
//   cs_flash_1, cs_flash_2  : flash selects, active low
//   miso_ena                : MISO buffer enable, high only in ACTIVE
//   busy                    : high outside IDLE and ACTIVE
//   sel_active              : one-hot selected flash, non-zero in ACTIVE only
module spi_select_sequencer
  import spi_select_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned GUARD_CYC  = 8,
  parameter logic [10:0] ADDR_SEL_1 = TBIOM_SPI_SEL_FLASH_1,
  parameter logic [10:0] ADDR_SEL_2 = TBIOM_SPI_SEL_FLASH_2
) (
  input  logic        clkDspIn,
  input  logic        dsp_reset,
  input  logic        we_deb,
  input  logic        re_deb,
  input  logic [10:0] ab_buf,
  output logic        cs_flash_1,
  output logic        cs_flash_2,
  output logic        miso_ena,
  output logic        busy,
  output logic [1:0]  sel_active
);

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GUARD_LD = 8'(GUARD_CYC - 1);

  seq_state_e state_q, state_d;
  pend_cmd_e  pend_q, pend_d, pend_kept;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_q, tgt_d;      // 0: flash 1, 1: flash 2
  logic       req1, req2, rel;
  logic [1:0] rel_mask;
  logic       sel_live;
  logic       cs1_q, cs1_d, cs2_q, cs2_d, miso_q, miso_d, busy_q, busy_d;
  logic [1:0] sel_q, sel_d;

  // A read releases a flash that is currently driven or is the pending request.
  assign sel_live    = cs_driven(state_q);
  assign rel_mask[0] = (sel_live & ~tgt_q) | (pend_q == PEND_REQ1);
  assign rel_mask[1] = (sel_live &  tgt_q) | (pend_q == PEND_REQ2);

  spi_select_sequencer_bus_event_detect #(
    .ADDR_SEL_1 (ADDR_SEL_1),
    .ADDR_SEL_2 (ADDR_SEL_2)
  ) u_evt (
    .clk_i      (clkDspIn),
    .rst_ni     (dsp_reset),
    .we_n_i     (we_deb),
    .re_n_i     (re_deb),
    .addr_i     (ab_buf),
    .rel_mask_i (rel_mask),
    .req1_o     (req1),
    .req2_o     (req2),
    .rel_o      (rel)
  );

  // Next-state, counter and pending-command logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    pend_kept = pend_q;
    case (state_q)
      ST_IDLE: begin
        case (pend_q)
          PEND_REQ1: begin
            state_d = ST_CS_SETUP; tgt_d = 1'b0; cnt_d = SETUP_LD; pend_kept = PEND_NONE;
          end
          PEND_REQ2: begin
            state_d = ST_CS_SETUP; tgt_d = 1'b1; cnt_d = SETUP_LD; pend_kept = PEND_NONE;
          end
          default: pend_kept = PEND_NONE;
        endcase
      end
      ST_CS_SETUP: begin
        if (cnt_q == 8'd0) state_d = ST_ACTIVE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_ACTIVE: begin
        // A request for the other flash stays pending and is served from IDLE.
        case (pend_q)
          PEND_REQ1: begin
            if (tgt_q == 1'b0) pend_kept = PEND_NONE;
            else               state_d   = ST_MISO_OFF;
          end
          PEND_REQ2: begin
            if (tgt_q == 1'b1) pend_kept = PEND_NONE;
            else               state_d   = ST_MISO_OFF;
          end
          PEND_REL: begin
            state_d = ST_MISO_OFF; pend_kept = PEND_NONE;
          end
          default: pend_kept = PEND_NONE;
        endcase
      end
      ST_MISO_OFF: begin
        state_d = ST_CS_HOLD; cnt_d = HOLD_LD;
      end
      ST_CS_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_GUARD; cnt_d = GUARD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = ST_IDLE; cnt_d = 8'd0; pend_kept = PEND_NONE;
      end
    endcase
    // A new command overwrites whatever is pending (last command wins).
    if (req1)      pend_d = PEND_REQ1;
    else if (req2) pend_d = PEND_REQ2;
    else if (rel)  pend_d = PEND_REL;
    else           pend_d = pend_kept;
  end

  // Output values decoded from the next state so the outputs leave flops.
  always_comb begin
    cs1_d  = ~(cs_driven(state_d) & ~tgt_d);
    cs2_d  = ~(cs_driven(state_d) &  tgt_d);
    miso_d = (state_d == ST_ACTIVE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_ACTIVE);
    if (state_d == ST_ACTIVE) sel_d = tgt_d ? 2'b10 : 2'b01;
    else                      sel_d = 2'b00;
  end

  // State, pending command, counter and registered outputs.
  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      state_q <= ST_IDLE;
      pend_q  <= PEND_NONE;
      cnt_q   <= 8'd0;
      tgt_q   <= 1'b0;
      cs1_q   <= 1'b1;
      cs2_q   <= 1'b1;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cs1_q   <= cs1_d;
      cs2_q   <= cs2_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  assign cs_flash_1 = cs1_q;
  assign cs_flash_2 = cs2_q;
  assign miso_ena   = miso_q;
  assign busy       = busy_q;
  assign sel_active = sel_q;

endmodule

// File: tb/tb_spi_select_sequencer.sv
// Scoreboard bench for spi_select_sequencer. Stimulus pushes each expected
// output transition (edge number and new output vector); the monitor pops one
// entry whenever the output vector changes and checks edge and value.
module tb_spi_select_sequencer;
  import spi_select_sequencer_pkg::*;

  localparam logic [10:0] A1 = TBIOM_SPI_SEL_FLASH_1;
  localparam logic [10:0] A2 = TBIOM_SPI_SEL_FLASH_2;
  // Output vector {cs_flash_1, cs_flash_2, miso_ena, busy, sel_active}
  localparam logic [5:0] V_IDLE = 6'b110000;
  localparam logic [5:0] V_S1   = 6'b010100;  // flash 1 CS low, busy
  localparam logic [5:0] V_A1   = 6'b011001;  // flash 1 active
  localparam logic [5:0] V_GD   = 6'b110100;  // guard
  localparam logic [5:0] V_S2   = 6'b100100;
  localparam logic [5:0] V_A2   = 6'b101010;

  typedef struct {
    int          cyc;
    logic [5:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        dsp_reset = 1'b1;
  logic        we_deb = 1'b1;
  logic        re_deb = 1'b1;
  logic [10:0] ab_buf = 11'd0;
  logic        cs_flash_1, cs_flash_2, miso_ena, busy;
  logic [1:0]  sel_active;
  logic [5:0]  outs, cur, prev;
  logic        done = 1'b0;
  exp_t        exp_q[$];
  exp_t        item;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          e, e2, e3;

  spi_select_sequencer dut (
    .clkDspIn   (clk),
    .dsp_reset  (dsp_reset),
    .we_deb     (we_deb),
    .re_deb     (re_deb),
    .ab_buf     (ab_buf),
    .cs_flash_1 (cs_flash_1),
    .cs_flash_2 (cs_flash_2),
    .miso_ena   (miso_ena),
    .busy       (busy),
    .sel_active (sel_active)
  );

  assign outs = {cs_flash_1, cs_flash_2, miso_ena, busy, sel_active};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  // Monitor: reset checks, invariants, scoreboard pops, final summary.
  always begin
    @(negedge clk or negedge dsp_reset);
    if (!dsp_reset) begin
      #1;
      n_total++;
      if (outs === V_IDLE) n_pass++;
      else $display("FAIL reset_outputs: actual %b required %b", outs, V_IDLE);
      prev = outs;
    end else if (done) begin
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL missing_transitions: actual %0d unseen required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end else begin
      cur = outs;
      n_total++;
      if (!(cur[5] == 1'b0 && cur[4] == 1'b0) && (cur[3] == 1'b0 || cur[1:0] != 2'b00))
        n_pass++;
      else
        $display("FAIL invariant at cycle %0d: actual %b", cyc, cur);
      if (cur !== prev) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change at cycle %0d: actual %b required %b", cyc, cur, prev);
        end else begin
          item = exp_q.pop_front();
          if (item.val === cur && item.cyc == cyc) n_pass++;
          else $display("FAIL transition: actual %b at cycle %0d required %b at cycle %0d",
                        cur, cyc, item.val, item.cyc);
        end
        prev = cur;
      end
    end
  end

  task automatic push(input int c, input logic [5:0] v);
    exp_t it;
    it.cyc = c;
    it.val = v;
    exp_q.push_back(it);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after an edge; ev returns the edge number that registers the event.
  task automatic wr(input logic [10:0] a, output int ev);
    ab_buf = a; we_deb = 1'b0; ev = cyc + 1;
    @(posedge clk); #1;
    we_deb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [10:0] a, output int ev);
    ab_buf = a; re_deb = 1'b0; ev = cyc + 1;
    @(posedge clk); #1;
    re_deb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wrrd(input logic [10:0] a, output int ev);
    ab_buf = a; we_deb = 1'b0; re_deb = 1'b0; ev = cyc + 1;
    @(posedge clk); #1;
    we_deb = 1'b1; re_deb = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 dsp_reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 dsp_reset = 1'b1;
    @(posedge clk); #1;

    // Select flash 1 from IDLE
    wr(A1, e); push(e + 1, V_S1); push(e + 5, V_A1);
    wait_until(e + 8);
    // Release flash 1
    rd(A1, e); push(e + 1, V_S1); push(e + 6, V_GD); push(e + 14, V_IDLE);
    wait_until(e + 16);

    // Switch flash 1 -> flash 2, then release flash 2
    wr(A1, e); push(e + 1, V_S1); push(e + 5, V_A1);
    wait_until(e + 7);
    wr(A2, e); push(e + 1, V_S1); push(e + 6, V_GD); push(e + 14, V_IDLE);
    push(e + 15, V_S2); push(e + 19, V_A2);
    wait_until(e + 21);
    rd(A2, e); push(e + 1, V_S2); push(e + 6, V_GD); push(e + 14, V_IDLE);
    wait_until(e + 16);

    // Two writes during GUARD: last one wins
    wr(A1, e); push(e + 1, V_S1); push(e + 5, V_A1);
    wait_until(e + 7);
    rd(A1, e); push(e + 1, V_S1); push(e + 6, V_GD);
    wait_until(e + 8);
    wr(A2, e2);
    wr(A1, e3);
    push(e + 14, V_IDLE); push(e + 15, V_S1); push(e + 19, V_A1);
    wait_until(e + 21);

    // Commands that must not change anything while flash 1 is active
    wr(11'h123, e2);
    rd(A2, e2);
    wr(A1, e2);
    rd(11'h055, e2);
    repeat (15) begin @(posedge clk); #1; end
    rd(A1, e); push(e + 1, V_S1); push(e + 6, V_GD); push(e + 14, V_IDLE);
    wait_until(e + 16);

    // Write and read on the same edge: write taken, read dropped
    wrrd(A1, e); push(e + 1, V_S1); push(e + 5, V_A1);
    wait_until(e + 10);
    rd(A1, e); push(e + 1, V_S1); push(e + 6, V_GD); push(e + 14, V_IDLE);
    wait_until(e + 16);

    // Reset during CS_SETUP
    wr(A1, e); push(e + 1, V_S1);
    wait_until(e + 2);
    #1 dsp_reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 dsp_reset = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    // Reset during CS_HOLD with a flash 2 request pending
    wr(A1, e); push(e + 1, V_S1); push(e + 5, V_A1);
    wait_until(e + 7);
    rd(A1, e); push(e + 1, V_S1);
    wr(A2, e2);
    #1 dsp_reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 dsp_reset = 1'b1;
    repeat (25) begin @(posedge clk); #1; end

    // Still operational afterwards
    wr(A2, e); push(e + 1, V_S2); push(e + 5, V_A2);
    wait_until(e + 8);
    done = 1'b1;
  end

endmodule
